// File: rtl/dram_slot_sequencer.sv
// 16-phase DRAM slot sequencer: Q/E, RAS/CAS/WE, mux select and refresh.
// Optional double-rate CPU mode under FAST_RATE_EN.
module dram_slot_sequencer #(
  parameter int REF_ROW_W   = 8,
  parameter int REF_BURST   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 OSCOut,
  input  logic                 RES,
  input  logic                 nHS,
  input  logic                 vid_req,
  input  logic                 cpu_req,
  input  logic                 RnW,
  input  logic                 fast,
  output logic [3:0]           phase,
  output logic                 Q,
  output logic                 E,
  output logic                 nRAS,
  output logic                 nCAS,
  output logic                 nWE,
  output logic                 mux_sel,
  output logic [1:0]           owner,
  output logic [REF_ROW_W-1:0] ref_row,
  output logic                 vid_ack,
  output logic                 vid_miss,
  output logic                 cpu_ack
);

  typedef enum logic [1:0] {
    OwnIdle = 2'd0,
    OwnVid  = 2'd1,
    OwnCpu  = 2'd2,
    OwnRef  = 2'd3
  } ownT;

  localparam logic [3:0] Burst = 4'(REF_BURST);

  ownT                    ownQ, ownNx;
  logic                   rnwQ, rnwNx;
  logic                   fastQ, fastNx;
  logic                   fastIn;
  logic [3:0]             pend, pendNx;
  logic [SYNC_STAGES-1:0] syncQ;
  logic                   hsPrev;
  logic                   hsFall;
  logic [3:0]             phaseNx;
  logic [2:0]             kNx;
  logic                   active;
  logic                   refDone;
  logic [REF_ROW_W-1:0]   rowNx;
  logic                   qNx, eNx;
  logic                   nRasNx, nCasNx, nWeNx, muxNx;
  logic                   vidAckNx, vidMissNx, cpuAckNx;

`ifdef FAST_RATE_EN
  assign fastIn = fast;
`else
  logic unusedFast;
  assign unusedFast = fast;
  assign fastIn     = 1'b0;
`endif

  assign owner  = ownQ;
  assign hsFall = hsPrev & ~syncQ[SYNC_STAGES-1];

  // Outputs are computed for the phase being entered, then registered.
  always_comb begin
    phaseNx   = phase + 4'd1;
    kNx       = phaseNx[2:0];
    ownNx     = ownQ;
    rnwNx     = rnwQ;
    fastNx    = fastQ;
    vidMissNx = 1'b0;
    if (kNx == 3'd0) begin
      fastNx = fastIn;
      ownNx  = OwnIdle;
      if (!phaseNx[3]) begin
        if (pend != 4'd0)
          ownNx = OwnRef;
        else if (fastIn && cpu_req)
          ownNx = OwnCpu;
        else if (!fastIn && vid_req)
          ownNx = OwnVid;
        vidMissNx = vid_req && (ownNx != OwnVid);
      end else if (cpu_req) begin
        ownNx = OwnCpu;
      end
      if (ownNx == OwnCpu)
        rnwNx = RnW;
    end
    if (kNx == 3'd7)
      ownNx = OwnIdle;

    active  = ownNx != OwnIdle;
    nRasNx  = !(active && kNx inside {[3'd1:3'd5]});
    muxNx   = active && kNx inside {[3'd2:3'd6]};
    nCasNx  = !(active && ownNx != OwnRef
                && kNx inside {[3'd3:3'd5]});
    nWeNx   = !(ownNx == OwnCpu && !rnwNx
                && kNx inside {[3'd3:3'd6]});

    vidAckNx = (kNx == 3'd6) && (ownQ == OwnVid);
    cpuAckNx = (kNx == 3'd6) && (ownQ == OwnCpu);
    refDone  = (kNx == 3'd6) && (ownQ == OwnRef);

    if (fastNx) begin
      qNx = kNx inside {[3'd2:3'd5]};
      eNx = kNx[2];
    end else begin
      qNx = phaseNx inside {[4'd4:4'd11]};
      eNx = phaseNx[3];
    end

    // A fresh hsync edge restarts the burst even mid-decrement.
    pendNx = pend;
    if (hsFall)
      pendNx = Burst;
    else if (refDone && pend != 4'd0)
      pendNx = pend - 4'd1;

    rowNx = refDone ? ref_row + REF_ROW_W'(1) : ref_row;
  end

  always_ff @(posedge OSCOut or posedge RES) begin
    if (RES) begin
      phase    <= 4'd0;
      ownQ     <= OwnIdle;
      rnwQ     <= 1'b1;
      fastQ    <= 1'b0;
      pend     <= 4'd0;
      syncQ    <= '1;
      hsPrev   <= 1'b1;
      ref_row  <= '0;
      Q        <= 1'b0;
      E        <= 1'b0;
      nRAS     <= 1'b1;
      nCAS     <= 1'b1;
      nWE      <= 1'b1;
      mux_sel  <= 1'b0;
      vid_ack  <= 1'b0;
      vid_miss <= 1'b0;
      cpu_ack  <= 1'b0;
    end else begin
      phase    <= phaseNx;
      ownQ     <= ownNx;
      rnwQ     <= rnwNx;
      fastQ    <= fastNx;
      pend     <= pendNx;
      syncQ[0] <= nHS;
      for (int i = 1; i < SYNC_STAGES; i++)
        syncQ[i] <= syncQ[i-1];
      hsPrev   <= syncQ[SYNC_STAGES-1];
      ref_row  <= rowNx;
      Q        <= qNx;
      E        <= eNx;
      nRAS     <= nRasNx;
      nCAS     <= nCasNx;
      nWE      <= nWeNx;
      mux_sel  <= muxNx;
      vid_ack  <= vidAckNx;
      vid_miss <= vidMissNx;
      cpu_ack  <= cpuAckNx;
    end
  end

endmodule
